// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the fifo_rr_scheduler block.
package fifo_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  localparam int STAT_W = 16;

  // Width of a FIFO index; never narrower than one bit.
  function automatic int id_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first eligible index at or after rr_ptr, with wrap.
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  localparam int ID_W = id_w(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] elig,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_idx
);

  localparam logic [ID_W:0] NUM_EXT = (ID_W+1)'(NUM_FIFOS);

  // Walk candidates farthest-first so the one nearest rr_ptr is written last.
  always_comb begin
    logic [ID_W:0]   sum_s;
    logic [ID_W:0]   wrap_s;
    logic [ID_W-1:0] idx_s;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum_s       = '0;
    wrap_s      = '0;
    idx_s       = '0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      sum_s       = {1'b0, rr_ptr} + (ID_W+1)'(k);
      wrap_s      = (sum_s >= NUM_EXT) ? (sum_s - NUM_EXT) : sum_s;
      idx_s       = wrap_s[ID_W-1:0];
      grant_valid = grant_valid | elig[idx_s];
      grant_idx   = elig[idx_s] ? idx_s : grant_idx;
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst scheduler draining NUM_FIFOS FWFT FIFOs onto one registered stream.
// Optional per-FIFO saturating grant counters are enabled with FIFO_SCHED_STATS_EN.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_FIFOS  = 4,
  parameter int BURST_LEN  = 4,
  localparam int ID_W = id_w(NUM_FIFOS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_FIFOS-1:0]            empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] dout,
  output logic [NUM_FIFOS-1:0]            rd_en,
  input  logic [NUM_FIFOS-1:0]            req_mask,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ID_W-1:0]                 out_id
`ifdef FIFO_SCHED_STATS_EN
  ,
  output logic [NUM_FIFOS*STAT_W-1:0]     grant_cnt
`endif
);

  localparam int              CNT_W     = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(NUM_FIFOS - 1);

  sched_state_t         state_r;
  sched_state_t         state_nxt_s;
  logic [ID_W-1:0]      rr_ptr_r;
  logic [ID_W-1:0]      cur_r;
  logic [CNT_W-1:0]     burst_cnt_r;
  logic [NUM_FIFOS-1:0] elig_s;
  logic                 load_s;
  logic                 stay_s;
  logic                 pick_valid_s;
  logic                 grant_s;
  logic [ID_W-1:0]      pick_idx_s;
  logic [ID_W-1:0]      grant_idx_s;

  assign elig_s    = req_mask & ~empty;
  assign load_s    = ~out_valid | out_ready;
  assign stay_s    = elig_s[cur_r] & (burst_cnt_r < BURST_MAX);
  // Gated by rst_n so no FIFO is popped while the block is held in reset.
  assign grant_s     = rst_n & load_s & (stay_s | pick_valid_s);
  assign grant_idx_s = stay_s ? cur_r : pick_idx_s;
  assign out_valid   = (state_r == HOLD);

  rr_pick #(
    .NUM_FIFOS(NUM_FIFOS)
  ) u_pick (
    .elig       (elig_s),
    .rr_ptr     (rr_ptr_r),
    .grant_valid(pick_valid_s),
    .grant_idx  (pick_idx_s)
  );

  // Next-state decode and the combinational read strobe for the granted FIFO.
  always_comb begin
    state_nxt_s = state_r;
    rd_en       = '0;
    if (grant_s) begin
      rd_en[grant_idx_s] = 1'b1;
    end else begin
      rd_en = '0;
    end
    case (state_r)
      IDLE:    state_nxt_s = grant_s ? HOLD : IDLE;
      HOLD:    state_nxt_s = (out_ready & ~grant_s) ? IDLE : HOLD;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, grant bookkeeping and output word capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      cur_r       <= '0;
      burst_cnt_r <= '0;
      out_data    <= '0;
      out_id      <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        out_data <= dout[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        out_id   <= grant_idx_s;
        cur_r    <= grant_idx_s;
        // Advancing the pointer on every grant keeps the first post-reset burst fair.
        rr_ptr_r <= (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + 1'b1);
        if (grant_idx_s != cur_r) begin
          burst_cnt_r <= CNT_W'(1);
        end else if (burst_cnt_r < BURST_MAX) begin
          burst_cnt_r <= burst_cnt_r + CNT_W'(1);
        end else begin
          burst_cnt_r <= burst_cnt_r;
        end
      end else begin
        out_data    <= out_data;
        out_id      <= out_id;
        cur_r       <= cur_r;
        rr_ptr_r    <= rr_ptr_r;
        burst_cnt_r <= burst_cnt_r;
      end
    end
  end

`ifdef FIFO_SCHED_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_r;

    // Saturating count of read strobes issued to FIFO i.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= '0;
      end else if (rd_en[i] && (cnt_r != STAT_MAX)) begin
        cnt_r <= cnt_r + STAT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign grant_cnt[i*STAT_W +: STAT_W] = cnt_r;
  end
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench: two scheduler instances (burst 4 and burst 1) against a queue-based model.
module tb_fifo_rr_scheduler;

  localparam int NF = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_mask;
  logic        out_ready;
  logic [3:0]  empty_l  [2];
  logic [31:0] dout_l   [2];
  logic [3:0]  rd_en_l  [2];
  logic        ov_l     [2];
  logic [7:0]  od_l     [2];
  logic [1:0]  oid_l    [2];
`ifdef FIFO_SCHED_STATS_EN
  logic [63:0] gcnt_l   [2];
`endif

  logic [7:0] fq    [2][4][$];
  word_t      exp_q [2][$];
  logic [1:0] dir_q [2][$];
  logic [3:0] exp_rd    [2];
  logic       exp_valid [2];
  logic       mv   [2];
  int         cur  [2];
  int         cnt  [2];
  int         ptr  [2];
  int         pend [2];
  int         gc   [2][4];
  logic       final_chk;
  int         checks;
  int         errors;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.DATA_WIDTH(DW), .NUM_FIFOS(NF), .BURST_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .empty(empty_l[0]), .dout(dout_l[0]), .rd_en(rd_en_l[0]),
    .req_mask(req_mask), .out_valid(ov_l[0]), .out_ready(out_ready), .out_data(od_l[0]),
    .out_id(oid_l[0])
`ifdef FIFO_SCHED_STATS_EN
    , .grant_cnt(gcnt_l[0])
`endif
  );

  fifo_rr_scheduler #(.DATA_WIDTH(DW), .NUM_FIFOS(NF), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .empty(empty_l[1]), .dout(dout_l[1]), .rd_en(rd_en_l[1]),
    .req_mask(req_mask), .out_valid(ov_l[1]), .out_ready(out_ready), .out_data(od_l[1]),
    .out_id(oid_l[1])
`ifdef FIFO_SCHED_STATS_EN
    , .grant_cnt(gcnt_l[1])
`endif
  );

  function automatic int bl_of(input int l);
    return (l == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", nm, l, $time, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] w);
    fq[0][i].push_back(w);
    fq[1][i].push_back(w);
  endtask

  task automatic drive_fifos();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < NF; i++) begin
        empty_l[l][i] = (fq[l][i].size() == 0);
        dout_l[l][i*DW +: DW] = (fq[l][i].size() != 0) ? fq[l][i][0] : 8'h00;
      end
    end
  endtask

  // Reference: decide this cycle's grant from the scheduling rules.
  task automatic model_eval(input int l);
    logic [3:0] el;
    int g;
    word_t w;
    pend[l] = -1;
    exp_rd[l] = 4'b0000;
    exp_valid[l] = mv[l];
    if (!rst_n) begin
      mv[l] = 1'b0; cur[l] = 0; cnt[l] = 0; ptr[l] = 0;
      exp_valid[l] = 1'b0;
      exp_q[l].delete();
      for (int i = 0; i < NF; i++) gc[l][i] = 0;
      return;
    end
    for (int i = 0; i < NF; i++) el[i] = req_mask[i] && (fq[l][i].size() != 0);
    g = -1;
    if ((!mv[l] || out_ready) && (el != 4'b0000)) begin
      if (el[cur[l]] && (cnt[l] < bl_of(l))) begin
        g = cur[l];
      end else begin
        for (int k = 0; k < NF; k++) begin
          if (el[(ptr[l] + k) % NF]) begin
            g = (ptr[l] + k) % NF;
            break;
          end
        end
      end
    end
    if (g >= 0) begin
      exp_rd[l][g] = 1'b1;
      w.data = fq[l][g][0];
      w.id = 2'(g);
      exp_q[l].push_back(w);
      cnt[l] = (g == cur[l]) ? ((cnt[l] < bl_of(l)) ? cnt[l] + 1 : cnt[l]) : 1;
      cur[l] = g;
      ptr[l] = (g + 1) % NF;
      mv[l] = 1'b1;
      pend[l] = g;
    end else if (!mv[l] || out_ready) begin
      mv[l] = 1'b0;
    end
  endtask

  task automatic step(input logic [3:0] m, input logic r);
    req_mask = m;
    out_ready = r;
    drive_fifos();
    for (int l = 0; l < 2; l++) model_eval(l);
    @(posedge clk);
    for (int l = 0; l < 2; l++) begin
      if (pend[l] >= 0) begin
        void'(fq[l][pend[l]].pop_front());
        if (gc[l][pend[l]] < 65535) gc[l][pend[l]]++;
      end
    end
    #1;
  endtask

  // Monitor: compares strobes and presented words with the scoreboard.
  always @(negedge clk) begin
    word_t h;
    for (int l = 0; l < 2; l++) begin
      if (!rst_n) begin
        chk("rst_rd_en", l, 32'(rd_en_l[l]), 32'd0);
        chk("rst_valid", l, 32'(ov_l[l]), 32'd0);
        chk("rst_data", l, 32'(od_l[l]), 32'd0);
        chk("rst_id", l, 32'(oid_l[l]), 32'd0);
      end else begin
        chk("rd_en", l, 32'(rd_en_l[l]), 32'(exp_rd[l]));
        chk("rd_en_legal", l, 32'(rd_en_l[l] & ~(req_mask & ~empty_l[l])), 32'd0);
        chk("out_valid", l, 32'(ov_l[l]), 32'(exp_valid[l]));
        if (ov_l[l]) begin
          if (exp_q[l].size() == 0) begin
            chk("unexpected_word", l, 32'd1, 32'd0);
          end else begin
            h = exp_q[l][0];
            chk("out_data", l, 32'(od_l[l]), 32'(h.data));
            chk("out_id", l, 32'(oid_l[l]), 32'(h.id));
            if (out_ready) begin
              void'(exp_q[l].pop_front());
              if (dir_q[l].size() != 0) chk("id_sequence", l, 32'(oid_l[l]), 32'(dir_q[l].pop_front()));
            end
          end
        end
        if (final_chk) begin
          chk("words_left", l, 32'(exp_q[l].size()), 32'd0);
          chk("sequence_left", l, 32'(dir_q[l].size()), 32'd0);
`ifdef FIFO_SCHED_STATS_EN
          for (int i = 0; i < NF; i++) chk("grant_cnt", l, 32'(gcnt_l[l][i*16 +: 16]), 32'(gc[l][i]));
`endif
        end
      end
    end
  end

  int rr4 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int rr1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int bu4 [8] = '{1, 1, 1, 1, 2, 2, 1, 1};
  int bu1 [8] = '{1, 2, 1, 2, 1, 1, 1, 1};

  initial begin
    logic [9:0] rdy_pat;
    logic [3:0] m;
    int busy;
    checks = 0;
    errors = 0;
    final_chk = 1'b0;
    rst_n = 1'b0;
    req_mask = 4'hF;
    out_ready = 1'b1;
    for (int l = 0; l < 2; l++) begin
      mv[l] = 1'b0; cur[l] = 0; cnt[l] = 0; ptr[l] = 0; pend[l] = -1;
    end
    drive_fifos();
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) step(4'hF, 1'b1);

    // Round robin: two words per FIFO.
    for (int k = 0; k < 8; k++) begin
      dir_q[0].push_back(2'(rr4[k]));
      dir_q[1].push_back(2'(rr1[k]));
    end
    for (int i = 0; i < NF; i++) for (int w = 0; w < 2; w++) push(i, 8'($urandom_range(0, 255)));
    for (int c = 0; c < 12; c++) step(4'hF, 1'b1);

    // Burst: FIFO1 six words, FIFO2 two words.
    for (int k = 0; k < 8; k++) begin
      dir_q[0].push_back(2'(bu4[k]));
      dir_q[1].push_back(2'(bu1[k]));
    end
    for (int w = 0; w < 6; w++) push(1, 8'($urandom_range(0, 255)));
    for (int w = 0; w < 2; w++) push(2, 8'($urandom_range(0, 255)));
    for (int c = 0; c < 12; c++) step(4'hF, 1'b1);

    // Backpressure: three stalled cycles on a valid word.
    for (int w = 0; w < 4; w++) push(2, 8'($urandom_range(0, 255)));
    rdy_pat = 10'b1111110001;
    for (int c = 0; c < 10; c++) step(4'hF, rdy_pat[c]);

    // Masked service with every FIFO non-empty.
    for (int i = 0; i < NF; i++) for (int w = 0; w < 2; w++) push(i, 8'($urandom_range(0, 255)));
    for (int c = 0; c < 8; c++) step(4'b1010, 1'b1);

    // Random traffic, a mid-stream reset, then more random traffic.
    m = 4'hF;
    for (int c = 0; c < 900; c++) begin
      if (c == 500) rst_n = 1'b0;
      if (c == 502) rst_n = 1'b1;
      for (int i = 0; i < NF; i++) if ($urandom_range(0, 7) == 0) push(i, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 15) == 0) m = 4'($urandom_range(0, 15));
      step(m, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

`ifdef FIFO_SCHED_STATS_EN
    // Continuous service of FIFO0 to drive its counter into saturation.
    for (int c = 0; c < 65540; c++) begin
      push(0, 8'($urandom_range(0, 255)));
      step(4'b0001, 1'b1);
    end
`endif

    // Drain, bounded.
    for (int c = 0; c < 800; c++) begin
      busy = 0;
      for (int l = 0; l < 2; l++) for (int i = 0; i < NF; i++) busy += fq[l][i].size();
      if (busy == 0) break;
      step(4'hF, 1'b1);
    end
    for (int c = 0; c < 3; c++) step(4'hF, 1'b1);
    final_chk = 1'b1;
    step(4'hF, 1'b1);
    final_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin read scheduler that drains a bank of `NUM_FIFOS` first-word-fall-through FIFOs (the `multiple_fifos` array) onto one registered valid/ready output stream. The scheduler watches the per-FIFO `empty` flags and drives the per-FIFO `rd_en` strobes. It captures the selected FIFO's `dout` slice into an output register and tags the word with its source FIFO index. A per-grant burst quantum lets one FIFO keep the grant for several consecutive words before the grant rotates.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of one FIFO word.
- `NUM_FIFOS`, default 4: number of FIFOs served. Legal range is 2..16.
- `BURST_LEN`, default 4: maximum consecutive grants to one FIFO. Legal range is 1..15.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `empty`, in, `NUM_FIFOS`: FIFO empty flags.
- `dout`, in, `NUM_FIFOS*DATA_WIDTH`: FIFO head words. Slice `i` is at `[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]`.
- `rd_en`, out, `NUM_FIFOS`: read strobes, at most one bit high.
- `req_mask`, in, `NUM_FIFOS`: 1 = FIFO eligible for service.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: downstream accepts the word.
- `out_data`, out, `DATA_WIDTH`: scheduled word.
- `out_id`, out, `ID_W`: source FIFO index. `ID_W = max(1, $clog2(NUM_FIFOS))`.

## Operation
- Eligibility: `elig[i] = req_mask[i] & ~empty[i]`.
- Load slot: `load = ~out_valid | out_ready`.
- Grant selection (combinational), evaluated when `load` is high and `elig != 0`:
  - If `cur` is eligible and `burst_cnt < BURST_LEN`, the grant stays on `cur`.
  - Otherwise the grant goes to the first eligible index at or after `rr_ptr`, searching upward with wrap.
- Grant effects:
  - `rd_en[g]` goes high in the same cycle.
  - On the next edge, `out_data <= dout[g]`, `out_id <= g`, `out_valid <= 1`.
- Grant bookkeeping:
  - On a grant to the same `cur`, `burst_cnt` increments.
  - On a new grant, `cur <= g`, `burst_cnt <= 1`, `rr_ptr <= (g+1) mod NUM_FIFOS`.
- No grant while `load` is high: `out_valid <= 0`. `cur` and `burst_cnt` hold; `burst_cnt` clears only on a grant to a different FIFO.
- Stall: while `out_valid & ~out_ready`, `out_data` and `out_id` hold and `rd_en` stays all-zero.
- `rd_en` is never asserted for an empty or masked FIFO. `rd_en` is all-zero while `rst_n` is low.
- Deasserting a `req_mask` bit takes effect in the same cycle. A word already in the output register is still delivered.
- State machine:
  - IDLE (`out_valid=0`) goes to HOLD on a grant.
  - HOLD (`out_valid=1`):
    - stays in HOLD on a stall;
    - stays in HOLD on `out_ready` with a grant (back-to-back);
    - goes to IDLE on `out_ready` without a grant.
- Wrap-around: `rr_ptr` after index `NUM_FIFOS-1` is 0.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_id=0`, `rd_en=0`, `rr_ptr=0`, `cur=0`, `burst_cnt=0`.
- Latency: a FIFO going non-empty in cycle N gives `rd_en` in N and `out_valid` in N+1.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Combinational path: `out_ready -> rd_en` is intentional. The downstream must not derive `out_ready` combinationally from `rd_en`.
- Reset mid-stream: the in-flight output word is dropped. FIFO contents are untouched by this block.

## Configuration
- Macro `FIFO_SCHED_STATS_EN`.
- Defined: adds output `grant_cnt`, `NUM_FIFOS*16` bits. These are per-FIFO 16-bit grant counters that increment on every `rd_en[i]`, saturate at 16'hFFFF, and reset to 0.
- Undefined: the port and the counters do not exist. The rest of the behaviour is identical.

## Structure
- Package `fifo_sched_pkg`:
  - state enum `{IDLE, HOLD}`;
  - `ID_W` helper function;
  - `STAT_W = 16` constant.
- Sub-module `rr_pick`: a combinational rotate-priority picker with inputs `elig` and `rr_ptr`, outputs `grant_valid` and `grant_idx`.
- The top level holds the FSM, burst counter, output register and stats.

## Test plan
- Reset: `rst_n=0` mid-stream → all outputs zero immediately. After release with all FIFOs empty, `out_valid` stays 0.
- Round-robin with `BURST_LEN=1`:
  - Setup: FIFOs 0..3 each hold 2 words, `out_ready=1`, mask all-ones.
  - Required: `out_id` sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
- Burst with `BURST_LEN=4`:
  - Setup: FIFO1 holds 6 words, FIFO2 holds 2 words.
  - Required: `out_id` sequence 1,1,1,1,2,2,1,1.
- Backpressure:
  - Setup: `out_ready=0` for 3 cycles with `out_valid=1`.
  - Required: `rd_en=0` and `out_data` stable. Release gives the next word one cycle later, with no loss or duplication.
- Mask and empty:
  - Setup: `req_mask=4'b1010`, all FIFOs non-empty.
  - Required: only FIFOs 1 and 3 are served, and `rd_en` never hits an empty FIFO (assertion).
- Stats (with `FIFO_SCHED_STATS_EN`): after the round-robin test, `grant_cnt` reads 2 per FIFO. A forced 65536-grant run saturates at 16'hFFFF.
